// File: rtl/exec_muldiv_unit.sv
// exec_muldiv_unit: iterative integer multiply/divide execution unit.
// One operand bit is processed per BUSY cycle (shift-add multiply,
// restoring divide on magnitudes); signs are applied when the result is
// presented in DONE.
// Optional feature macro: MULDIV_EARLY_OUT_EN (divide-by-zero / signed
// overflow skip BUSY; multiply stops once the remaining multiplier bits are zero).
//
// Handshakes: a uop transfers on a rising edge where state is IDLE,
// u_valid=1 and flush=0 (u_stall is high in every other state). A result
// transfers on a rising edge where d_valid=1 and d_stall=0; while d_stall=1
// the result outputs are held. flush overrides both handshakes.
module exec_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             u_valid,
    output logic             u_stall,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  s1,
    input  logic [XLEN-1:0]  s2,
    input  logic [TAG_W-1:0] rd_in,
    input  logic             flush,
    output logic             d_valid,
    input  logic             d_stall,
    output logic [TAG_W-1:0] rd_out,
    output logic [XLEN-1:0]  rd_val,
    output logic [1:0]       flags,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_nx;

    // latched uop
    logic [2:0]       op_q;
    logic [TAG_W-1:0] rd_q;
    logic [XLEN-1:0]  s1_q;
    logic             neg_q;   // product / quotient must be negated
    logic             rneg_q;  // remainder must be negated
    logic             dz_q;    // divide by zero
    logic             ovf_q;   // signed divide overflow

    // datapath
    logic [2*XLEN-1:0] acc;    // product accumulator
    logic [2*XLEN-1:0] mc;     // multiplicand (shifts left) / divisor in low half
    logic [XLEN-1:0]   mp;     // multiplier (shifts right) / dividend->quotient
    logic [XLEN-1:0]   rem;    // partial remainder
    logic [CNT_W-1:0]  cnt;

    // operand decode at accept
    logic            is_div, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf, accept;
    logic [XLEN-1:0] a_mag, b_mag;

    // one restoring-divide step
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] sub;

    // multiply termination
    logic [XLEN-1:0] mp_shr;
    logic            last, mul_done;

    // result formation
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   mul_res, quo_c, rem_c, quo_res, rem_res, result;

    // Decode operand signedness and magnitudes for an incoming uop
    always_comb begin
        is_div   = op[2];
        a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg    = a_signed && s1[XLEN-1];
        b_neg    = b_signed && s2[XLEN-1];
        a_mag    = a_neg ? -s1 : s1;
        b_mag    = b_neg ? -s2 : s2;
        div_zero = is_div && (s2 == '0);
        div_ovf  = is_div && b_signed && (s1 == MIN_NEG) && (s2 == '1);
        accept   = (state == IDLE) && u_valid && !flush;
    end

    // Per-cycle arithmetic step helpers
    always_comb begin
        shifted = {rem, mp[XLEN-1]};
        ge      = shifted >= {1'b0, mc[XLEN-1:0]};
        sub     = shifted[XLEN-1:0] - mc[XLEN-1:0];
        mp_shr  = mp >> 1;
        last    = (cnt == CNT_W'(XLEN - 1));
`ifdef MULDIV_EARLY_OUT_EN
        mul_done = !op_q[2] && (mp_shr == '0);
`else
        mul_done = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; flush beats both accept and d_stall
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = BUSY;
`ifdef MULDIV_EARLY_OUT_EN
                    if (div_zero || div_ovf) state_nx = DONE;
`endif
                end
            end
            BUSY: begin
                if (flush)                 state_nx = IDLE;
                else if (last || mul_done) state_nx = DONE;
            end
            DONE: begin
                if (flush || !d_stall) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latch the uop on accept, then advance one bit per BUSY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            rd_q   <= '0;
            s1_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            acc    <= '0;
            mc     <= '0;
            mp     <= '0;
            rem    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            op_q   <= op;
            rd_q   <= rd_in;
            s1_q   <= s1;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            dz_q   <= div_zero;
            ovf_q  <= div_ovf;
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
            mp     <= is_div ? a_mag : b_mag;
            mc     <= {{XLEN{1'b0}}, (is_div ? b_mag : a_mag)};
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            if (op_q[2]) begin
                rem <= ge ? sub : shifted[XLEN-1:0];
                mp  <= {mp[XLEN-2:0], ge};
            end else begin
                if (mp[0]) acc <= acc + mc;
                mc <= mc << 1;
                mp <= mp_shr;
            end
        end
    end

    // Sign correction and special-case override, visible only in DONE
    always_comb begin
        prod_c  = neg_q ? -acc : acc;
        mul_res = (op_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
        quo_c   = neg_q ? -mp : mp;
        rem_c   = rneg_q ? -rem : rem;
        quo_res = quo_c;
        rem_res = rem_c;
        if (dz_q) begin
            quo_res = '1;
            rem_res = s1_q;
        end else if (ovf_q) begin
            quo_res = s1_q;
            rem_res = '0;
        end
        result    = op_q[2] ? (op_q[1] ? rem_res : quo_res) : mul_res;
        d_valid   = (state == DONE);
        u_stall   = (state != IDLE);
        rd_val    = d_valid ? result : '0;
        rd_out    = d_valid ? rd_q : '0;
        flags     = d_valid ? {(result == '0), result[XLEN-1]} : 2'b00;
        state_dbg = state;
    end

endmodule

// File: tb/tb_exec_muldiv_unit.sv
module tb_exec_muldiv_unit;

    logic        clk, rst, u_valid, u_stall, flush, d_valid, d_stall;
    logic [2:0]  op;
    logic [31:0] s1, s2, rd_val;
    logic [4:0]  rd_in, rd_out;
    logic [1:0]  flags, state_dbg;

    exec_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .u_valid(u_valid), .u_stall(u_stall), .op(op),
        .s1(s1), .s2(s2), .rd_in(rd_in), .flush(flush), .d_valid(d_valid),
        .d_stall(d_stall), .rd_out(rd_out), .rd_val(rd_val), .flags(flags),
        .state_dbg(state_dbg)
    );

    typedef struct {
        logic [31:0] val;
        logic [4:0]  tag;
        logic [1:0]  flg;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   seen = 0;
    bit   rand_stall = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural result from plain integer arithmetic
    function automatic logic [31:0] ref_val(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, ps;
        logic [63:0] pu, ua64, ub64;
        int          ia, ib;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        ia = $signed(a);
        ib = $signed(b);
        r = '0;
        case (o)
            3'd0: r = a * b;
            3'd1: begin ps = sa * sb; r = ps[63:32]; end
            3'd2: begin ps = sa * ub; r = ps[63:32]; end
            3'd3: begin pu = ua64 * ub64; r = pu[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Cycles from the accepting edge until DONE is entered
    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] m;
        int n;
        if (o >= 3'd4) begin
            if (b == 0 || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                return 0;
            return 32;
        end
        m = (o == 3'd1 && b[31]) ? -b : b;
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return n;
`else
        return 32 + 0 * int'(o) + 0 * int'(a[0]) + 0 * int'(b[0]);
`endif
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input bit expect_it);
        int guard;
        exp_t e;
        guard = 0;
        tick();
        while (u_stall && guard < 300) begin
            tick();
            guard++;
        end
        if (u_stall) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: u_stall got 1 expected 0 after %0d cycles", guard);
        end
        u_valid = 1;
        op = o;
        s1 = a;
        s2 = b;
        rd_in = t;
        if (expect_it) begin
            e.val = ref_val(o, a, b);
            e.tag = t;
            e.flg = {e.val == 0, e.val[31]};
            e.due = cyc + 1 + ref_lat(o, a, b);
            exp_q.push_back(e);
        end
        tick();
        u_valid = 0;
        s1 = $urandom;
        s2 = $urandom;
        op = 3'($urandom_range(0, 7));
        rd_in = 5'($urandom_range(0, 31));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            tick();
            g++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
            seen = 0;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && d_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_d_valid: got rd_val %0h rd_out %0d with no result expected", rd_val, rd_out);
            end else begin
                if (!seen) chk("latency_cycle", 64'(cyc), 64'(exp_q[0].due));
                seen = 1;
                chk("rd_val", 64'(rd_val), 64'(exp_q[0].val));
                chk("rd_out", 64'(rd_out), 64'(exp_q[0].tag));
                chk("flags", 64'(flags), 64'(exp_q[0].flg));
                if (!d_stall) begin
                    void'(exp_q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    // Random downstream back-pressure
    always @(posedge clk) begin
        if (rand_stall) begin
            #1;
            d_stall = ($urandom_range(0, 2) == 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1;
        u_valid = 0;
        flush = 0;
        d_stall = 0;
        op = 0;
        s1 = 0;
        s2 = 0;
        rd_in = 0;
        tick();
        tick();
        chk("reset_d_valid", 64'(d_valid), 64'd0);
        chk("reset_u_stall", 64'(u_stall), 64'd0);
        chk("reset_rd_val", 64'(rd_val), 64'd0);
        chk("reset_rd_out", 64'(rd_out), 64'd0);
        chk("reset_flags", 64'(flags), 64'd0);
        chk("reset_state", 64'(state_dbg), 64'd0);
        rst = 0;

        // directed vectors
        issue(3'd0, 32'd7, 32'd6, 5'd3, 1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 1);
        issue(3'd5, 32'd100, 32'd7, 5'd6, 1);
        issue(3'd7, 32'd100, 32'd7, 5'd7, 1);
        issue(3'd5, 32'h1234, 32'd0, 5'd8, 1);
        issue(3'd7, 32'h1234, 32'd0, 5'd9, 1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd12, 1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 1);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 1);
        issue(3'd0, 32'h1234_5678, 32'd0, 5'd15, 1);
        drain();

        // flush in IDLE beats a simultaneous request
        tick();
        u_valid = 1;
        flush = 1;
        op = 3'd0;
        s1 = 32'd3;
        s2 = 32'd3;
        tick();
        u_valid = 0;
        flush = 0;
        chk("flush_beats_accept_u_stall", 64'(u_stall), 64'd0);

        // flush at accept+10
        issue(3'd5, 32'd1000, 32'd3, 5'd16, 0);
        repeat (9) tick();
        flush = 1;
        tick();
        flush = 0;
        chk("flush_u_stall", 64'(u_stall), 64'd0);
        chk("flush_d_valid", 64'(d_valid), 64'd0);
        issue(3'd1, 32'hFFFF_FFFE, 32'd5, 5'd17, 1);
        drain();

        // reset pulse at accept+20
        issue(3'd6, 32'd99, 32'd10, 5'd18, 0);
        repeat (19) tick();
        #2;
        rst = 1;
        #1;
        chk("async_rst_u_stall", 64'(u_stall), 64'd0);
        chk("async_rst_d_valid", 64'(d_valid), 64'd0);
        chk("async_rst_rd_out", 64'(rd_out), 64'd0);
        tick();
        rst = 0;
        chk("post_rst_state", 64'(state_dbg), 64'd0);
        issue(3'd4, 32'd77, 32'hFFFF_FFF5, 5'd19, 1);
        drain();

        // downstream stall held for 5 cycles in DONE
        d_stall = 1;
        issue(3'd0, 32'hABCD, 32'h11, 5'd20, 1);
        begin
            int g;
            g = 0;
            while (!d_valid && g < 100) begin
                tick();
                g++;
            end
        end
        chk("stall_d_valid_reached", 64'(d_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_u_stall", 64'(u_stall), 64'd1);
        end
        d_stall = 0;
        chk("stall_release_u_stall", 64'(u_stall), 64'd1);
        issue(3'd7, 32'd55, 32'd8, 5'd21, 1);
        drain();

        // randomized traffic with random back-pressure
        rand_stall = 1;
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
                  5'($urandom_range(0, 31)), 1);
        end
        drain();
        rand_stall = 0;
        tick();
        d_stall = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exec_muldiv_unit.md
EXEC_MULDIV_UNIT -- requirements
Module: exec_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port u_valid  input  1  upstream uop valid.
REQ-006 SHALL have port u_stall  output  1  upstream must hold uop.
REQ-007 SHALL have port op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have ports s1, s2  input  XLEN  operands, already bypassed.
REQ-009 SHALL have port rd_in  input  TAG_W  destination tag.
REQ-010 SHALL have port flush  input  1  cancel in-flight op (branch redirect).
REQ-011 SHALL have port d_valid  output  1  result valid.
REQ-012 SHALL have port d_stall  input  1  downstream hold.
REQ-013 SHALL have ports rd_out  output  TAG_W, rd_val  output  XLEN, flags  output  2 ({z,s} of rd_val).

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-015 SHALL accept on edge with state IDLE, u_valid=1, flush=0; latch op, operands, rd_in; go BUSY.
REQ-016 SHALL drive u_stall=1 whenever state != IDLE.
REQ-017 SHALL process one bit per BUSY cycle (shift-add multiply, restoring divide on magnitudes), XLEN BUSY cycles, then DONE.
REQ-018 SHALL, without early-out, assert d_valid exactly XLEN+1 cycles after the accepting edge.
REQ-019 SHALL apply sign correction in DONE: MUL low half, MULH/MULHSU/MULHU high half of 2*XLEN product; quotient sign = s1^s2, remainder sign = s1.
REQ-020 SHALL on divide by zero return quotient all-ones and remainder = s1.
REQ-021 SHALL on signed overflow (s1 = -2^(XLEN-1), s2 = -1) return quotient s1, remainder 0.
REQ-022 SHALL hold d_valid, rd_out, rd_val, flags stable in DONE while d_stall=1.
REQ-023 SHALL leave DONE to IDLE on edge with d_stall=0; new uop accepted no earlier than next edge.
REQ-024 SHALL on flush=1 in BUSY or DONE return to IDLE next edge, d_valid=0; flush beats accept and d_stall.
REQ-025 SHALL compute flags.z = (rd_val==0), flags.s = rd_val[XLEN-1].

Reset
REQ-026 SHALL on rst=1 immediately enter IDLE, d_valid=0, u_stall=0, rd_out=0, rd_val=0, flags=0, regardless of cycle position.
REQ-027 SHALL discard any in-flight op on reset; no result emitted after release.

Configuration
REQ-028 SHALL honour macro MULDIV_EARLY_OUT_EN.
REQ-029 SHALL, with MULDIV_EARLY_OUT_EN defined: divide-by-zero and signed overflow go IDLE->DONE directly (d_valid 1 cycle after accept); multiply ends BUSY once remaining multiplier bits are all zero (minimum 1 BUSY cycle).
REQ-030 SHALL, without MULDIV_EARLY_OUT_EN, use fixed latency per REQ-018 for all ops and all operands.

Verification
REQ-031 SHALL cover MUL s1=7 s2=6 rd=3 -> d_valid at accept+33, rd_val=42, rd_out=3, flags=00.
REQ-032 SHALL cover DIV s1=0xFFFFFFF9 s2=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF, flags=01; DIVU 100/7 -> 14, REMU -> 2.
REQ-033 SHALL cover DIVU s2=0 s1=0x1234 -> 0xFFFFFFFF; REMU -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0 (flags=10); with MULDIV_EARLY_OUT_EN, d_valid at accept+1.
REQ-034 SHALL cover MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 SHALL cover d_stall=1 for 5 cycles in DONE -> outputs frozen, u_stall=1; next uop accepted only after d_stall drops.
REQ-036 SHALL cover flush at accept+10 and rst pulse at accept+20 of separate ops -> IDLE next edge (rst: immediately), no d_valid, back-to-back accept succeeds.
